// File: rtl/led_pkg.sv
// Shared types and constants for the LED scroll sequencer.
package led_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } scroll_state_t;

  localparam int LED_DIGITS = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Scroll step timebase: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle step on the terminal count. Held at 0 while disabled or cleared.
module led_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick;

  // A clear also suppresses the step, so home/stop win over an advance.
  assign step = en && !clr && (tick == TICK_LAST);

  // Tick counter: free-runs in SCROLL, rolls over on the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else if (!en || clr || (tick == TICK_LAST)) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

endmodule

// File: rtl/led_scroll_ctrl.sv
// Scrolls a 4-digit window across a nibble message buffer for the LED driver.
// Optional macro LED_SCROLL_DIR_EN adds a 'dir' input for reverse scrolling.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | tick held at 0, window position frozen
// SCROLL | tick running, position advances every TICK_DIV
module led_scroll_ctrl
  import led_pkg::*;
#(
  parameter int MSG_LEN  = 16,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       home,
`ifdef LED_SCROLL_DIR_EN
  input  logic                       dir,
`endif
  output logic [3:0]                 hex3,
  output logic [3:0]                 hex2,
  output logic [3:0]                 hex1,
  output logic [3:0]                 hex0,
  output logic                       busy,
  output logic                       wrap
);

  localparam int AW = $clog2(MSG_LEN);
  localparam logic [AW-1:0] POS_LAST = AW'(MSG_LEN - 1);

  scroll_state_t state, state_nxt;
  nibble_t       msg [MSG_LEN];
  nibble_t       window [LED_DIGITS];
  logic [AW-1:0] pos, pos_nxt;
  logic          wrap_nxt;
  logic          step;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == SCROLL),
    .clr   (home || stop),
    .step  (step)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: stop has priority over a simultaneous start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = SCROLL;
      SCROLL:  if (stop)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Position update; home overrides an advance and never flags a wrap.
  always_comb begin
    pos_nxt  = pos;
    wrap_nxt = 1'b0;
    if (home) begin
      pos_nxt = '0;
    end else if (step) begin
`ifdef LED_SCROLL_DIR_EN
      if (dir) begin
        pos_nxt  = pos - AW'(1);
        wrap_nxt = (pos == '0);
      end else begin
        pos_nxt  = pos + AW'(1);
        wrap_nxt = (pos == POS_LAST);
      end
`else
      pos_nxt  = pos + AW'(1);
      wrap_nxt = (pos == POS_LAST);
`endif
    end
  end

  // Position, wrap pulse and busy flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos  <= '0;
      wrap <= 1'b0;
      busy <= 1'b0;
    end else begin
      pos  <= pos_nxt;
      wrap <= wrap_nxt;
      busy <= (state == SCROLL);
    end
  end

  // Message buffer: flop array so all four window digits read in parallel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= '0;
    end else if (wr_en) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Window register; indices wrap naturally through the pos width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < LED_DIGITS; d++) window[d] <= '0;
    end else begin
      for (int d = 0; d < LED_DIGITS; d++) window[d] <= msg[pos + AW'(d)];
    end
  end

  assign hex3 = window[0];
  assign hex2 = window[1];
  assign hex1 = window[2];
  assign hex0 = window[3];

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Directed bench for led_scroll_ctrl with TICK_DIV=4, MSG_LEN=16.
module tb_led_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       home = 1'b0;
`ifdef LED_SCROLL_DIR_EN
  logic       dir = 1'b0;
`endif
  logic [3:0] hex3, hex2, hex1, hex0;
  logic       busy, wrap;

  int n_cmp  = 0;
  int n_fail = 0;
  int wraps;

  led_scroll_ctrl #(
    .MSG_LEN  (16),
    .TICK_DIV (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .home    (home),
`ifdef LED_SCROLL_DIR_EN
    .dir     (dir),
`endif
    .hex3    (hex3),
    .hex2    (hex2),
    .hex1    (hex1),
    .hex0    (hex0),
    .busy    (busy),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_wrap", {15'd0, wrap}, 16'd0);
    cyc();
    reset = 1'b0;

    // Load msg[i] = i while idle
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
      cyc();
    end
    wr_en = 1'b0;
    cyc(); cyc();
    check("idle_win", {hex3, hex2, hex1, hex0}, 16'h0123);
    check("idle_busy", {15'd0, busy}, 16'd0);
    repeat (10) cyc();
    check("idle_hold", {hex3, hex2, hex1, hex0}, 16'h0123);

    // Start scrolling: edge E0 enters SCROLL
    start = 1'b1;
    cyc();                                   // E0
    start = 1'b0;
    check("busy_e0", {15'd0, busy}, 16'd0);
    cyc();                                   // E1
    check("busy_e1", {15'd0, busy}, 16'd1);
    cyc(); cyc(); cyc();                     // E4: first advance
    check("win_e4", {hex3, hex2, hex1, hex0}, 16'h0123);
    cyc();                                   // E5
    check("win_e5", {hex3, hex2, hex1, hex0}, 16'h1234);
    cyc(); cyc(); cyc();                     // E8
    check("win_e8", {hex3, hex2, hex1, hex0}, 16'h1234);
    cyc();                                   // E9
    check("win_e9", {hex3, hex2, hex1, hex0}, 16'h2345);

    // start while scrolling must not disturb the tick
    start = 1'b1;
    cyc();                                   // E10
    start = 1'b0;
    cyc(); cyc(); cyc();                     // E13
    check("start_ign", {hex3, hex2, hex1, hex0}, 16'h3456);

    // Run up to the wrap; window at pos=14 visible after E57
    wraps = 0;
    for (int e = 14; e <= 57; e++) begin
      cyc();
      if (wrap) wraps++;
    end
    check("win_pos14", {hex3, hex2, hex1, hex0}, 16'hEF01);
    for (int e = 58; e <= 63; e++) begin
      cyc();
      if (wrap) wraps++;
    end
    check("no_early_wrap", 16'(wraps), 16'd0);
    cyc();                                   // E64: pos becomes 0
    check("wrap_e64", {15'd0, wrap}, 16'd1);
    cyc();                                   // E65
    check("wrap_e65", {15'd0, wrap}, 16'd0);
    check("win_e65", {hex3, hex2, hex1, hex0}, 16'h0123);

    // Advance to pos=2 (E72), shown after E73
    repeat (8) cyc();                        // E73
    check("win_e73", {hex3, hex2, hex1, hex0}, 16'h2345);

    // start+stop together: stop wins
    start = 1'b1; stop = 1'b1;
    cyc();                                   // E74
    start = 1'b0; stop = 1'b0;
    check("busy_stop0", {15'd0, busy}, 16'd1);
    cyc();
    check("busy_stop1", {15'd0, busy}, 16'd0);
    repeat (10) cyc();
    check("frozen_win", {hex3, hex2, hex1, hex0}, 16'h2345);
    check("frozen_busy", {15'd0, busy}, 16'd0);

    // home while idle: window back to 0, no wrap
    home = 1'b1;
    cyc();
    home = 1'b0;
    check("home_wrap0", {15'd0, wrap}, 16'd0);
    cyc();
    check("home_win", {hex3, hex2, hex1, hex0}, 16'h0123);
    check("home_wrap1", {15'd0, wrap}, 16'd0);

    // Write msg[pos+2]=A in the same cycle as the first step (S4)
    start = 1'b1;
    cyc();                                   // S0
    start = 1'b0;
    cyc(); cyc(); cyc();                     // S3
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hA;
    cyc();                                   // S4: step + write
    wr_en = 1'b0;
    cyc();                                   // S5
    check("wr_step_win", {hex3, hex2, hex1, hex0}, 16'h1A34);

    // Asynchronous reset mid-step
    cyc();
    #2;
    reset = 1'b1;
    #1;
    check("arst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_wrap", {15'd0, wrap}, 16'd0);
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    check("post_rst_win", {hex3, hex2, hex1, hex0}, 16'h0000);
    check("post_rst_busy", {15'd0, busy}, 16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    check("post_rst_scroll", {hex3, hex2, hex1, hex0}, 16'h0000);
    check("post_rst_busy1", {15'd0, busy}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
